mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving busy cycles for a multiply-class op.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving busy cycles for a divide-class op.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  op request, sampled on rising clk.
REQ-007 op  input  4  operation code: MULT, MULTU, DIV, DIVU, MTHI, MTLO; MADD, MADDU, MSUB, MSUBU only with the macro.
REQ-008 a  input  32  rs operand.
REQ-009 b  input  32  rt operand.
REQ-010 cancel  input  1  abort the in-flight op (exception/flush).
REQ-011 busy  output  1  op in flight; the pipeline stalls MDU instructions while high.
REQ-012 hi  output  32  HI register.
REQ-013 lo  output  32  LO register.

Function
REQ-014 The FSM SHALL have two states, IDLE and BUSY, plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE, start with a multiply/divide-class op SHALL latch a, b and op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY at the same edge.
REQ-016 busy SHALL be high in exactly MULT_CYCLES or DIV_CYCLES consecutive cycles, starting the cycle after start is accepted.
REQ-017 hi and lo SHALL update at the edge that ends the last busy cycle; busy falls at that same edge, and the FSM returns to IDLE.
REQ-018 MTHI and MTLO SHALL write a into hi or lo at the accepting edge, with no busy cycle.
REQ-019 start while BUSY SHALL be ignored, with no state change; issuing again is the pipeline's responsibility.
REQ-020 An unknown op code with start SHALL be ignored.
REQ-021 MULT and MULTU SHALL produce a 64-bit signed or unsigned product: hi = product[63:32], lo = product[31:0].
REQ-022 DIV and DIVU SHALL give lo = quotient and hi = remainder; the signed quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-024 Division by zero SHALL take the full DIV_CYCLES and leave hi and lo unchanged.
REQ-025 cancel in BUSY SHALL return the FSM to IDLE at the next edge, drop busy, and leave hi and lo unchanged.
REQ-026 cancel and start in the same cycle SHALL leave the start unaccepted, including MTHI and MTLO.
REQ-027 cancel in the final busy cycle SHALL suppress the hi/lo commit.
REQ-028 Operands SHALL be used only in their latched form; changes on a and b during BUSY have no effect.

Reset
REQ-029 reset low SHALL asynchronously force state IDLE, cnt = 0, busy = 0, hi = 0, lo = 0, and clear the latched operands.
REQ-030 reset asserted mid-operation SHALL discard the op; the first accepted start after release behaves as from power-up.
REQ-031 Reset release SHALL be synchronised by the instantiating top, not inside this block.

Configuration
REQ-032 Macro MDU_MADD_EN SHALL enable MADD, MADDU, MSUB and MSUBU.
REQ-033 With MDU_MADD_EN, each of these ops SHALL compute {hi,lo} = {hi,lo} ± product, modulo 2^64, with MULT_CYCLES latency, using the {hi,lo} value at commit time.
REQ-034 Without MDU_MADD_EN, these op codes SHALL be treated as unknown (REQ-020), and no accumulate adder is synthesised.

Structure
REQ-035 Package mdu_pkg SHALL hold the op-code constants, the state encoding, and the MULT_CYCLES and DIV_CYCLES defaults.
REQ-036 One combinational sub-module, mdu_arith, SHALL compute the 64-bit {hi,lo} result from the latched operands, the op, and the current {hi,lo}.
REQ-037 mdu_ctrl SHALL hold the FSM, the counter, the operand latches and the HI/LO registers.

Verification
REQ-038 Scenario 1: MULT a=0xFFFFFFFE, b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-039 Scenario 2: DIV a=0xFFFFFFF9 (-7), b=2 -> busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> hi and lo unchanged after 10 cycles.
REQ-040 Scenario 3: MULTU 0x10000 x 0x10000, then MTLO a=0x1234 during BUSY -> MTLO ignored, result hi=1, lo=0; MTLO reissued after busy falls -> lo=0x1234.
REQ-041 Scenario 4: DIV started, cancel in busy cycle 10 -> busy low at the next edge, prior hi/lo retained; cancel together with start of MTHI -> hi unchanged.
REQ-042 Scenario 5: reset pulled low in busy cycle 3 of MULT, between clock edges -> busy, hi and lo are 0 immediately; next MULT 2x3 -> lo=6 after 5 cycles.
REQ-043 Scenario 6 (MDU_MADD_EN): hi=0, lo=0xFFFFFFFF, then MADDU 1x1 -> hi=1, lo=0; without the macro the same op leaves busy low.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM state encoding and default latencies for the
// multiply/divide unit. The MADD/MADDU/MSUB/MSUBU codes are decoded only
// when the MDU_MADD_EN macro is defined.
package mdu_pkg;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    // Ops that occupy the unit for MULT_CYCLES.
    function automatic logic is_mult_class(input logic [3:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Ops that occupy the unit for DIV_CYCLES.
    function automatic logic is_div_class(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational {hi,lo} result for the latched op and operands.
// A single 64-bit multiplier serves signed and unsigned ops (operands are
// sign- or zero-extended first); a single unsigned divider serves DIV and
// DIVU (signed division works on magnitudes and fixes signs afterwards).
// Division by zero returns the current {hi,lo}, so the commit is a no-op.
// MDU_MADD_EN adds the accumulate/subtract path.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic        w_mul_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;

    logic        w_div_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

`ifdef MDU_MADD_EN
    logic [63:0] w_acc;
    logic [63:0] w_acc_add;
    logic [63:0] w_acc_sub;
`endif

    assign w_mul_signed = (i_op == OP_MULT)
`ifdef MDU_MADD_EN
                        || (i_op == OP_MADD) || (i_op == OP_MSUB)
`endif
                        ;
    assign w_ext_a = w_mul_signed ? {{32{i_a[31]}}, i_a} : {32'h0, i_a};
    assign w_ext_b = w_mul_signed ? {{32{i_b[31]}}, i_b} : {32'h0, i_b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Two's-complement negation of 0x80000000 is itself, which as an
    // unsigned magnitude is exactly 2^31, so the overflow case needs no
    // special handling: 0x80000000 / 1 negated gives 0x80000000, rem 0.
    assign w_div_signed = (i_op == OP_DIV);
    assign w_mag_a = (w_div_signed && i_a[31]) ? (~i_a + 32'd1) : i_a;
    assign w_mag_b = (w_div_signed && i_b[31]) ? (~i_b + 32'd1) : i_b;
    assign w_q_mag = w_mag_a / w_mag_b;
    assign w_r_mag = w_mag_a % w_mag_b;
    assign w_quot  = (w_div_signed && (i_a[31] ^ i_b[31])) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem   = (w_div_signed && i_a[31]) ? (~w_r_mag + 32'd1) : w_r_mag;

`ifdef MDU_MADD_EN
    assign w_acc     = {i_hi, i_lo};
    assign w_acc_add = w_acc + w_prod;
    assign w_acc_sub = w_acc - w_prod;
`endif

    // Select the result for the latched op; anything else keeps {hi,lo}.
    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        case (i_op)
            OP_MULT, OP_MULTU: begin
                o_hi = w_prod[63:32];
                o_lo = w_prod[31:0];
            end
            OP_DIV, OP_DIVU: begin
                if (i_b != 32'h0) begin
                    o_hi = w_rem;
                    o_lo = w_quot;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: begin
                o_hi = w_acc_add[63:32];
                o_lo = w_acc_add[31:0];
            end
            OP_MSUB, OP_MSUBU: begin
                o_hi = w_acc_sub[63:32];
                o_lo = w_acc_sub[31:0];
            end
`endif
            default: begin
                o_hi = i_hi;
                o_lo = i_lo;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller. IDLE/BUSY FSM with a
// down-counter, operand latches and the HI/LO registers. MTHI/MTLO write
// directly in IDLE. Optional MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    state_e         r_state;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_a;
    logic [31:0]    r_b;
    logic [3:0]     r_op;
    logic [31:0]    r_hi;
    logic [31:0]    r_lo;

    state_e         w_state_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [31:0]    w_a_nxt;
    logic [31:0]    w_b_nxt;
    logic [3:0]     w_op_nxt;
    logic [31:0]    w_hi_nxt;
    logic [31:0]    w_lo_nxt;

    logic           w_is_mul;
    logic           w_is_div;
    logic [31:0]    w_res_hi;
    logic [31:0]    w_res_lo;

    assign w_is_mul = is_mult_class(op);
    assign w_is_div = is_div_class(op);

    mdu_arith u_arith (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .i_hi (r_hi),
        .i_lo (r_lo),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo)
    );

    // State, counter, operand latches and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Next-state logic: accept in IDLE (cancel blocks acceptance), count down
    // in BUSY, commit the arith result on the last busy cycle unless cancelled.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    if (w_is_mul || w_is_div) begin
                        w_a_nxt     = a;
                        w_b_nxt     = b;
                        w_op_nxt    = op;
                        w_cnt_nxt   = w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                        w_state_nxt = S_BUSY;
                    end else if (op == OP_MTHI) begin
                        w_hi_nxt = a;
                    end else if (op == OP_MTLO) begin
                        w_lo_nxt = a;
                    end
                end
            end
            S_BUSY: begin
                if (cancel) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt <= CW'(1)) begin
                    w_hi_nxt    = w_res_hi;
                    w_lo_nxt    = w_res_lo;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (r_state == S_BUSY);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table of hand-computed vectors, hand-written corner-case
// sequences (overlapping start, cancel, async reset, accumulate), then
// random ops against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[11];

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: HI/LO effect and busy length from the op definitions.
    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, output int cyc);
        int sx;
        int sy;
        longint sp;
        longint unsigned up;
        longint unsigned acc;
        sx  = int'(x);
        sy  = int'(y);
        sp  = longint'(sx) * longint'(sy);
        up  = longint'(x) * longint'(y);
        acc = {m_hi, m_lo};
        cyc = 0;
        case (o)
            4'd0: begin cyc = MC; {m_hi, m_lo} = sp; end
            4'd1: begin cyc = MC; {m_hi, m_lo} = up; end
            4'd2: begin
                cyc = DC;
                if (y != 0) begin
                    if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
                        m_lo = 32'h80000000;
                        m_hi = 32'h0;
                    end else begin
                        m_lo = sx / sy;
                        m_hi = sx % sy;
                    end
                end
            end
            4'd3: begin
                cyc = DC;
                if (y != 0) begin
                    m_lo = x / y;
                    m_hi = x % y;
                end
            end
            4'd4: m_hi = x;
            4'd5: m_lo = x;
`ifdef MDU_MADD_EN
            4'd6: begin cyc = MC; {m_hi, m_lo} = acc + longint'(sp); end
            4'd7: begin cyc = MC; {m_hi, m_lo} = acc + up; end
            4'd8: begin cyc = MC; {m_hi, m_lo} = acc - longint'(sp); end
            4'd9: begin cyc = MC; {m_hi, m_lo} = acc - up; end
`endif
            default: cyc = 0;
        endcase
    endtask

    // Present one start for one edge, then scramble the operand inputs.
    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count consecutive busy cycles, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_model(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int ec;
        int n;
        model(o, x, y, ec);
        issue(o, x, y);
        wait_idle(n);
        chk({nm, "_cycles"}, 64'(n), 64'(ec));
        chk({nm, "_hilo"}, {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        int n;
        vectors     = 0;
        miscompares = 0;
        reset  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 4'd0;
        a      = '0;
        b      = '0;
        m_hi   = '0;
        m_lo   = '0;

        tbl[0]  = '{4'd0, 32'hFFFFFFFE, 32'd3,        MC, 32'hFFFFFFFF, 32'hFFFFFFFA};
        tbl[1]  = '{4'd2, 32'hFFFFFFF9, 32'd2,        DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[2]  = '{4'd3, 32'd7,        32'd0,        DC, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{4'd2, 32'h80000000, 32'hFFFFFFFF, DC, 32'h00000000, 32'h80000000};
        tbl[4]  = '{4'd4, 32'hAAAA5555, 32'd0,        0,  32'hAAAA5555, 32'h80000000};
        tbl[5]  = '{4'd5, 32'h00001234, 32'd0,        0,  32'hAAAA5555, 32'h00001234};
        tbl[6]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, MC, 32'hFFFFFFFE, 32'h00000001};
        tbl[7]  = '{4'd15, 32'd9,       32'd9,        0,  32'hFFFFFFFE, 32'h00000001};
        tbl[8]  = '{4'd3, 32'd100,      32'd7,        DC, 32'h00000002, 32'h0000000E};
        tbl[9]  = '{4'd2, 32'd7,        32'hFFFFFFFE, DC, 32'h00000001, 32'hFFFFFFFD};
        tbl[10] = '{4'd0, 32'd7,        32'hFFFFFFFF, MC, 32'hFFFFFFFF, 32'hFFFFFFF9};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b);
            wait_idle(n);
            chk($sformatf("tbl%0d_cycles", i), 64'(n), 64'(tbl[i].cyc));
            chk($sformatf("tbl%0d_hilo", i), {hi, lo}, {tbl[i].hi, tbl[i].lo});
        end
        m_hi = tbl[10].hi;
        m_lo = tbl[10].lo;

        // Start of MTLO while busy is ignored; busy length unchanged.
        begin
            int ec;
            model(4'd1, 32'h10000, 32'h10000, ec);
            issue(4'd1, 32'h10000, 32'h10000);
            @(negedge clk);
            start = 1'b1;
            op    = 4'd5;
            a     = 32'h1234;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_idle(n);
            chk("ovl_cycles", 64'(n + 1), 64'(ec));
            chk("ovl_hilo", {hi, lo}, 64'h00000001_00000000);
            run_model("mtlo_after", 4'd5, 32'h1234, 32'd0);
            chk("mtlo_lo", 64'(lo), 64'h1234);
        end

        // Cancel in the final busy cycle suppresses the commit.
        issue(4'd3, 32'd100, 32'd7);
        repeat (DC - 1) begin
            @(posedge clk);
            #1;
        end
        chk("cancel_last_busy", 64'(busy), 64'd1);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_busy_low", 64'(busy), 64'd0);
        chk("cancel_hilo", {hi, lo}, {m_hi, m_lo});

        // Cancel together with MTHI start: not accepted.
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 4'd4;
        a      = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        chk("cancel_mthi_busy", 64'(busy), 64'd0);
        chk("cancel_mthi_hilo", {hi, lo}, {m_hi, m_lo});

        // Asynchronous reset between edges in busy cycle 3.
        issue(4'd0, 32'd5, 32'd5);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("areset_busy", 64'(busy), 64'd0);
        chk("areset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        run_model("post_reset_mult", 4'd0, 32'd2, 32'd3);
        chk("post_reset_lo", 64'(lo), 64'd6);

        // Accumulate from hi=0, lo=0xFFFFFFFF.
        run_model("acc_mthi", 4'd4, 32'd0, 32'd0);
        run_model("acc_mtlo", 4'd5, 32'hFFFFFFFF, 32'd0);
        issue(4'd7, 32'd1, 32'd1);
        wait_idle(n);
`ifdef MDU_MADD_EN
        chk("maddu_cycles", 64'(n), 64'(MC));
        chk("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
        m_hi = 32'd1;
        m_lo = 32'd0;
`else
        chk("maddu_cycles", 64'(n), 64'd0);
        chk("maddu_hilo", {hi, lo}, 64'h00000000_FFFFFFFF);
`endif

        // Random ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_model($sformatf("rnd%0d", i), ro, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
